// File: rtl/fp_addsub.sv
// fp_addsub: iterative IEEE-754-style adder/subtractor with a start/busy/ready
// handshake. An operation walks ALIGN -> ADD -> NORM -> ROUND, so the result
// lands exactly four clock edges after the accepted start edge. Subnormals are
// flushed to zero and rounding is round-to-nearest-even.
`timescale 1ns/1ps

module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   data_a,
    input  logic [EXP_W+MAN_W:0]   data_b,
    output logic                   busy,
    output logic                   ready,
    output logic [EXP_W+MAN_W:0]   data_o,
    output logic                   overflow,
    output logic                   invalid
);

    localparam int W  = EXP_W + MAN_W + 1;   // word width
    localparam int SW = MAN_W + 4;           // hidden + fraction + guard/round/sticky
    localparam int XW = EXP_W + 2;           // signed working exponent width

    localparam logic [EXP_W-1:0]        EXP_ONES = '1;
    localparam logic signed [XW-1:0]    EXP_MAX  = XW'((2 ** EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t state;
    logic   start_q;
    logic   accept;

    // captured operands
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         op_q;

    // shared working registers; only one operation is ever in flight
    logic [SW-1:0]          big_q;
    logic [SW-1:0]          sml_q;
    logic [SW:0]            sum_q;
    logic [SW-1:0]          norm_q;
    logic signed [XW-1:0]   exp_q;
    logic                   sign_q;
    logic                   sub_q;
    logic                   zero_q;
    logic                   spc_q;
    logic [W-1:0]           spc_res_q;
    logic                   spc_inv_q;

    // operand fields
    logic               sa, sb_eff;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;

    assign sa     = a_q[W-1];
    assign sb_eff = b_q[W-1] ^ op_q;
    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];

    // A start event is a 0->1 transition of the sampled start; only idle/done accept it
    assign accept = start && !start_q && (state == S_IDLE || state == S_DONE);

    // ---------------------------------------------------------------------
    // ALIGN: order by magnitude and shift the smaller significand right
    // ---------------------------------------------------------------------
    logic               a_ge;
    logic [EXP_W-1:0]   exp_big, exp_sml;
    logic [MAN_W-1:0]   frac_big, frac_sml;
    logic               sign_big, sign_sml;
    logic [31:0]        diff, shamt;
    logic [2*SW-1:0]    wide;
    logic [SW-1:0]      big_sig, sml_sh;

    // Swap, then shift with every bit pushed past the sticky position ORed into sticky
    always_comb begin
        a_ge     = (a_q[W-2:0] >= b_q[W-2:0]);
        exp_big  = a_ge ? ea : eb;
        exp_sml  = a_ge ? eb : ea;
        frac_big = a_ge ? fa : fb;
        frac_sml = a_ge ? fb : fa;
        sign_big = a_ge ? sa : sb_eff;
        sign_sml = a_ge ? sb_eff : sa;
        diff     = 32'(exp_big) - 32'(exp_sml);
        shamt    = (diff > 32'(SW)) ? 32'(SW) : diff;
        wide     = {1'b1, frac_sml, 3'b000, {SW{1'b0}}} >> shamt;
        sml_sh   = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
        big_sig  = {1'b1, frac_big, 3'b000};
    end

    // Special operands: decided in ALIGN and carried unchanged to the output
    logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic         spc_c, spc_inv_c;
    logic [W-1:0] spc_res_c;

    // Priority: NaN / inf-inf, then infinity, then zero cases
    always_comb begin
        a_zero    = (ea == '0);
        b_zero    = (eb == '0);
        a_inf     = (ea == EXP_ONES) && (fa == '0);
        b_inf     = (eb == EXP_ONES) && (fb == '0);
        a_nan     = (ea == EXP_ONES) && (fa != '0);
        b_nan     = (eb == EXP_ONES) && (fb != '0);
        spc_c     = 1'b1;
        spc_inv_c = 1'b0;
        spc_res_c = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb_eff))) begin
            spc_res_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            spc_inv_c = 1'b1;
        end else if (a_inf) begin
            spc_res_c = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spc_res_c = {sb_eff, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            spc_res_c = {sa & sb_eff, {(W-1){1'b0}}};
        end else if (a_zero) begin
            // the effective B operand (sign already folded with op)
            spc_res_c = {sb_eff, b_q[W-2:0]};
        end else if (b_zero) begin
            spc_res_c = a_q;
        end else begin
            spc_c = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // ADD: magnitude add or subtract; big >= small so the difference is never negative
    // ---------------------------------------------------------------------
    logic [SW:0] sum_c;

    // One extra bit catches the carry out of an addition
    always_comb begin
        if (sub_q)
            sum_c = {1'b0, big_q} - {1'b0, sml_q};
        else
            sum_c = {1'b0, big_q} + {1'b0, sml_q};
    end

    // ---------------------------------------------------------------------
    // NORM: fix up the carry or remove leading zeros
    // ---------------------------------------------------------------------
    int                     msb;
    int                     lz;
    logic signed [XW-1:0]   norm_exp_c;
    logic [SW-1:0]          norm_c;
    logic                   norm_zero_c;
    logic                   norm_sign_c;

    // Leading-zero count is purely combinational over the sum below the carry bit
    always_comb begin
        msb = 0;
        for (int i = 0; i < SW; i++) begin
            if (sum_q[i])
                msb = i;
        end
        lz          = SW - 1 - msb;
        norm_c      = sum_q[SW-1:0];
        norm_exp_c  = exp_q;
        norm_zero_c = 1'b0;
        norm_sign_c = sign_q;
        if (sum_q[SW]) begin
            norm_c     = {sum_q[SW:2], sum_q[1] | sum_q[0]};
            norm_exp_c = exp_q + XW'(1);
        end else if (sum_q == '0) begin
            norm_zero_c = 1'b1;
            norm_sign_c = 1'b0;
        end else begin
            norm_c     = sum_q[SW-1:0] << lz;
            norm_exp_c = exp_q - XW'(lz);
            if (norm_exp_c[XW-1] || norm_exp_c == '0)
                norm_zero_c = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // ROUND: nearest-even, with the rounding carry bumping the exponent
    // ---------------------------------------------------------------------
    logic                   rnd_inc;
    logic [MAN_W+1:0]       mant;
    logic signed [XW-1:0]   rexp;
    logic [MAN_W-1:0]       frac_r;
    logic [W-1:0]           round_res_c;
    logic                   round_ovf_c;

    // Increment when G & (R | S | lsb); an exponent at all-ones becomes infinity
    always_comb begin
        rnd_inc     = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
        mant        = {1'b0, norm_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
        rexp        = mant[MAN_W+1] ? (exp_q + XW'(1)) : exp_q;
        frac_r      = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
        round_ovf_c = 1'b0;
        if (zero_q) begin
            round_res_c = {sign_q, {(W-1){1'b0}}};
        end else if (rexp >= EXP_MAX) begin
            round_res_c = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            round_ovf_c = 1'b1;
        end else begin
            round_res_c = {sign_q, rexp[EXP_W-1:0], frac_r};
        end
    end

    // Datapath registers: each stage loads its results while the FSM sits in it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            big_q     <= '0;
            sml_q     <= '0;
            sum_q     <= '0;
            norm_q    <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            sub_q     <= 1'b0;
            zero_q    <= 1'b0;
            spc_q     <= 1'b0;
            spc_res_q <= '0;
            spc_inv_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q  <= data_a;
                        b_q  <= data_b;
                        op_q <= op;
                    end
                end
                S_ALIGN: begin
                    big_q     <= big_sig;
                    sml_q     <= sml_sh;
                    exp_q     <= $signed({2'b00, exp_big});
                    sign_q    <= sign_big;
                    sub_q     <= (sign_big != sign_sml);
                    spc_q     <= spc_c;
                    spc_res_q <= spc_res_c;
                    spc_inv_q <= spc_inv_c;
                end
                S_ADD: begin
                    sum_q <= sum_c;
                end
                S_NORM: begin
                    norm_q <= norm_c;
                    exp_q  <= norm_exp_c;
                    zero_q <= norm_zero_c;
                    sign_q <= norm_sign_c;
                end
                default: begin
                end
            endcase
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            data_o   <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        state <= S_ALIGN;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                S_ALIGN: state <= S_ADD;
                S_ADD:   state <= S_NORM;
                S_NORM:  state <= S_ROUND;
                S_ROUND: begin
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    ready    <= 1'b1;
                    data_o   <= spc_q ? spc_res_q : round_res_c;
                    overflow <= spc_q ? 1'b0 : round_ovf_c;
                    invalid  <= spc_q ? spc_inv_q : 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: single-precision instance plus a half-precision
// instance (EXP_W=5, MAN_W=10), checking handshake timing, results and flags.
`timescale 1ns/1ps

module tb_fp_addsub;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;

    logic        s_start, s_op, s_busy, s_ready, s_ovf, s_inv;
    logic [31:0] s_a, s_b, s_o;

    logic        h_start, h_op, h_busy, h_ready, h_ovf, h_inv;
    logic [15:0] h_a, h_b, h_o;

    int errors = 0;
    int checks = 0;

    fp_addsub #(.EXP_W(8), .MAN_W(23)) dut_s (
        .clock(clock), .reset_n(reset_n), .start(s_start), .op(s_op),
        .data_a(s_a), .data_b(s_b), .busy(s_busy), .ready(s_ready),
        .data_o(s_o), .overflow(s_ovf), .invalid(s_inv)
    );

    fp_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clock(clock), .reset_n(reset_n), .start(h_start), .op(h_op),
        .data_a(h_a), .data_b(h_b), .busy(h_busy), .ready(h_ready),
        .data_o(h_o), .overflow(h_ovf), .invalid(h_inv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_data(input bit half);
        return half ? {16'h0, h_o} : s_o;
    endfunction
    function automatic logic [31:0] o_busy(input bit half);
        return 32'(half ? h_busy : s_busy);
    endfunction
    function automatic logic [31:0] o_ready(input bit half);
        return 32'(half ? h_ready : s_ready);
    endfunction
    function automatic logic [31:0] o_ovf(input bit half);
        return 32'(half ? h_ovf : s_ovf);
    endfunction
    function automatic logic [31:0] o_inv(input bit half);
        return 32'(half ? h_inv : s_inv);
    endfunction

    // One full transaction: start edge k, busy through k+3, result at k+4
    task automatic run_op(input string tag, input bit half, input logic [31:0] a,
                          input logic [31:0] b, input logic o, input logic [31:0] exp_res,
                          input logic exp_ov, input logic exp_inv);
        @(negedge clock);
        if (half) begin
            h_a = a[15:0]; h_b = b[15:0]; h_op = o; h_start = 1'b1;
        end else begin
            s_a = a; s_b = b; s_op = o; s_start = 1'b1;
        end
        @(posedge clock); #1;
        chk({tag, ".busy_k"}, o_busy(half), 32'd1);
        chk({tag, ".ready_k"}, o_ready(half), 32'd0);
        @(negedge clock);
        s_start = 1'b0;
        h_start = 1'b0;
        repeat (2) @(posedge clock);
        @(posedge clock); #1;
        chk({tag, ".busy_k3"}, o_busy(half), 32'd1);
        chk({tag, ".ready_k3"}, o_ready(half), 32'd0);
        @(posedge clock); #1;
        chk({tag, ".ready_k4"}, o_ready(half), 32'd1);
        chk({tag, ".busy_k4"}, o_busy(half), 32'd0);
        chk({tag, ".data"}, o_data(half), exp_res);
        chk({tag, ".ovf"}, o_ovf(half), 32'(exp_ov));
        chk({tag, ".inv"}, o_inv(half), 32'(exp_inv));
        $display("txn %-10s a=0x%08h b=0x%08h op=%0d -> data=0x%08h ovf=%0d inv=%0d",
                 tag, a, b, o, o_data(half), o_ovf(half), o_inv(half));
    endtask

    initial begin
        reset_n = 1'b0;
        s_start = 1'b0; s_op = 1'b0; s_a = '0; s_b = '0;
        h_start = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0;
        repeat (2) @(posedge clock); #1;
        chk("rst.s_data", s_o, 32'h0);
        chk("rst.s_busy", 32'(s_busy), 32'd0);
        chk("rst.s_ready", 32'(s_ready), 32'd0);
        chk("rst.s_flags", {30'd0, s_ovf, s_inv}, 32'd0);
        chk("rst.h_data", {16'h0, h_o}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // basic add, subtraction, cancellation
        run_op("add_1_2",  1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        run_op("sub_3_1",  1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b0);
        run_op("sub_1_1",  1'b0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        run_op("sub_lnorm", 1'b0, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 1'b0);
        // rounding
        run_op("rnd_tie",  1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run_op("rnd_up",   1'b0, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        run_op("rnd_odd",  1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
        // specials
        run_op("ovf_max",  1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        run_op("ninf_p1",  1'b0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
        run_op("subn_0",   1'b0, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        // half precision sweep
        run_op("h_add_1_1", 1'b1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 1'b0, 1'b0);
        run_op("h_ovf",     1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 1'b1, 1'b0);

        // start edge mid-operation is ignored; holding start high starts nothing
        @(negedge clock);
        s_a = 32'h3F800000; s_b = 32'h40000000; s_op = 1'b0; s_start = 1'b1;
        @(posedge clock); #1;
        chk("mid.busy_k", 32'(s_busy), 32'd1);
        @(negedge clock);
        s_start = 1'b0;
        @(negedge clock);
        s_a = 32'h40400000; s_b = 32'h3F800000; s_op = 1'b1; s_start = 1'b1;
        @(posedge clock); #1;
        chk("mid.busy_k2", 32'(s_busy), 32'd1);
        repeat (2) @(posedge clock); #1;
        chk("mid.ready_k4", 32'(s_ready), 32'd1);
        chk("mid.data_k4", s_o, 32'h40400000);
        repeat (2) @(posedge clock); #1;
        chk("mid.busy_k6", 32'(s_busy), 32'd0);
        chk("mid.ready_k6", 32'(s_ready), 32'd1);
        chk("mid.data_k6", s_o, 32'h40400000);
        $display("txn mid_ignore start at k+2 ignored, data=0x%08h", s_o);
        @(negedge clock);
        s_start = 1'b0;

        // back-to-back: inf-inf then an add started while DONE
        run_op("inf_m_inf", 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        run_op("b2b_add",   1'b0, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0);
        run_op("inf_m_inf2", 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);

        // reset pulse at k+2 clears everything immediately
        @(negedge clock);
        s_a = 32'h3F800000; s_b = 32'h40000000; s_op = 1'b0; s_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        s_start = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid.data", s_o, 32'h0);
        chk("rstmid.busy", 32'(s_busy), 32'd0);
        chk("rstmid.ready", 32'(s_ready), 32'd0);
        chk("rstmid.flags", {30'd0, s_ovf, s_inv}, 32'd0);
        chk("rstmid.h_data", {16'h0, h_o}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(posedge clock); #1;
        chk("rstmid.ready_after", 32'(s_ready), 32'd0);
        chk("rstmid.busy_after", 32'(s_busy), 32'd0);
        chk("rstmid.data_after", s_o, 32'h0);
        $display("txn reset_mid busy=%0d ready=%0d data=0x%08h", s_busy, s_ready, s_o);

        run_op("post_rst", 1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
